// File: rtl/seq_shifter_pkg.sv
// Shared types for the multi-cycle shift unit.
// Op encodings and FSM state typedef.
package seq_shifter_pkg;

  typedef enum logic [1:0] {
    OP_SLL = 2'b00,
    OP_SRL = 2'b01,
    OP_SRA = 2'b10,
    OP_ROR = 2'b11
  } op_t;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } shstate_t;

endpackage

// File: rtl/seq_shifter_if.sv
// Start/done bundle between control unit and shifter.
// master: start, op, a, shamt out; busy, done, result in.
interface seq_shifter_if
  import seq_shifter_pkg::*;
#(
  parameter int XLEN = 32
);
  localparam int SHW = $clog2(XLEN);

  logic            start;
  op_t             op;
  logic [XLEN-1:0] a;
  logic [SHW-1:0]  shamt;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, op, a, shamt,
    input  busy, done, result
  );

  modport slave (
    input  start, op, a, shamt,
    output busy, done, result
  );
endinterface

// File: rtl/seq_shifter_shift_step.sv
// Combinational single step: shift i_val by i_k.
// Ports: i_val, i_k, i_op, i_fill -> o_val.
// SEQ_SHIFTER_ROTATE_EN enables ROR; else op 11 is SRL.
module shift_step
  import seq_shifter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 4,
  parameter int KW   = $clog2(STEP + 1)
) (
  input  logic [XLEN-1:0] i_val,
  input  logic [KW-1:0]   i_k,
  input  op_t             i_op,
  input  logic            i_fill,
  output logic [XLEN-1:0] o_val
);
  localparam int SHW = $clog2(XLEN);

  logic [XLEN-1:0] w_srl;
  logic [XLEN-1:0] w_fmask;
`ifdef SEQ_SHIFTER_ROTATE_EN
  logic [SHW:0]    w_lamt;
`endif

  always_comb begin
    w_srl   = i_val >> i_k;
    // ones where SRA must insert the sign
    w_fmask = ~({XLEN{1'b1}} >> i_k);
`ifdef SEQ_SHIFTER_ROTATE_EN
    // k=0 gives a shift by XLEN, i.e. zero
    w_lamt  = (SHW+1)'(XLEN) - (SHW+1)'(i_k);
`endif
    o_val   = w_srl;
    unique case (1'b1)
      (i_op == OP_SLL):
        o_val = i_val << i_k;
      (i_op == OP_SRA):
        o_val = w_srl | (i_fill ? w_fmask : '0);
`ifdef SEQ_SHIFTER_ROTATE_EN
      (i_op == OP_ROR):
        o_val = w_srl | (i_val << w_lamt);
`endif
      default:
        o_val = w_srl;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle SLL/SRL/SRA/ROR unit, STEP bits per cycle.
// Ports: clk, rst (async low), bus (slave modport).
// SEQ_SHIFTER_ROTATE_EN enables ROR; else op 11 is SRL.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input logic          clk,
  input logic          rst,
  seq_shifter_if.slave bus
);
  localparam int SHW = $clog2(XLEN);
  localparam int KW  = $clog2(STEP + 1);

  shstate_t        r_state;
  logic [XLEN-1:0] r_work;
  op_t             r_op;
  logic            r_fill;
  logic [SHW:0]    r_rem;
  logic            r_busy;
  logic            r_done;
  logic [XLEN-1:0] r_result;

  logic [KW-1:0]   w_k;
  logic            w_last;
  logic [XLEN-1:0] w_next;

  always_comb begin
    w_last = (r_rem <= (SHW+1)'(STEP));
    w_k    = w_last ? r_rem[KW-1:0]
                    : KW'(STEP);
  end

  shift_step #(
    .XLEN (XLEN),
    .STEP (STEP),
    .KW   (KW)
  ) u_step (
    .i_val  (r_work),
    .i_k    (w_k),
    .i_op   (r_op),
    .i_fill (r_fill),
    .o_val  (w_next)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_work   <= '0;
      r_op     <= OP_SLL;
      r_fill   <= 1'b0;
      r_rem    <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= 1'b0;
      unique case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_work  <= bus.a;
            r_op    <= bus.op;
            r_fill  <= bus.a[XLEN-1];
            r_rem   <= {1'b0, bus.shamt};
            r_busy  <= 1'b1;
            r_state <= SHIFT;
          end
        end
        SHIFT: begin
          r_work <= w_next;
          r_rem  <= r_rem - (SHW+1)'(w_k);
          // rem<=STEP: this step drains it (also rem=0)
          if (w_last) begin
            r_result <= w_next;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy   = r_busy;
  assign bus.done   = r_done;
  assign bus.result = r_result;

endmodule

// File: tb/tb_seq_shifter.sv
// Scoreboard bench for seq_shifter, XLEN=32 STEP=4.
// Honors SEQ_SHIFTER_ROTATE_EN for op 11 expectations.
module tb_seq_shifter;
  import seq_shifter_pkg::*;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  logic [31:0] exp_q[$];
  int          lat_q[$];

  seq_shifter_if #(.XLEN(32)) bus ();

  seq_shifter #(
    .XLEN (32),
    .STEP (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(
    input op_t op, input logic [31:0] a,
    input int sh);
    logic [31:0] v;
    v = a;
    for (int i = 0; i < sh; i++) begin
      case (op)
        OP_SLL: v = {v[30:0], 1'b0};
        OP_SRA: v = {a[31], v[31:1]};
`ifdef SEQ_SHIFTER_ROTATE_EN
        OP_ROR: v = {v[0], v[31:1]};
`endif
        default: v = {1'b0, v[31:1]};
      endcase
    end
    return v;
  endfunction

  // call at a negedge; returns at the negedge after capture
  task automatic issue(input op_t op,
    input logic [31:0] a, input int sh);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.shamt = 5'(sh);
    exp_q.push_back(model(op, a, sh));
    lat_q.push_back((sh == 0) ? 1 : (sh + 3) / 4);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // returns at the negedge where done is seen
  task automatic wait_done(output int cyc,
    output bit tmo, output bit ovl, output bit stb);
    logic [31:0] ref_r;
    bit seen;
    ref_r = bus.result;
    cyc = 0; ovl = 0; stb = 1; seen = 0;
    for (int i = 0; i < 200; i++) begin
      if (bus.busy && bus.done) ovl = 1;
      if (bus.done) begin
        seen = 1;
        break;
      end
      if (bus.busy) cyc++;
      if (bus.result !== ref_r) stb = 0;
      @(negedge clk);
    end
    tmo = !seen;
  endtask

  task automatic pop_exp(output logic [31:0] e,
    output int n);
    e = 'x; n = -1;
    if (exp_q.size() > 0) e = exp_q.pop_front();
    if (lat_q.size() > 0) n = lat_q.pop_front();
  endtask

  task automatic test_reset();
    n_tests++;
    if (bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_busy got %b want 0", bus.busy);
    end
    n_tests++;
    if (bus.done !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_done got %b want 0", bus.done);
    end
    n_tests++;
    if (bus.result !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_result got %h want 0",
        bus.result);
    end
  endtask

  task automatic test_sra();
    int c, n; bit t, o, s; logic [31:0] e;
    issue(OP_SRA, 32'h8000_0010, 5);
    wait_done(c, t, o, s);
    pop_exp(e, n);
    n_tests++;
    if (t || bus.result !== 32'hFC00_0000) begin
      n_fail++;
      $display("FAIL sra_result got %h want fc000000 tmo=%0b",
        bus.result, t);
    end
    n_tests++;
    if (bus.result !== e) begin
      n_fail++;
      $display("FAIL sra_sb got %h want %h", bus.result, e);
    end
    n_tests++;
    if (c !== 2 || c !== n) begin
      n_fail++;
      $display("FAIL sra_busy got %0d want 2", c);
    end
    n_tests++;
    if (o) begin
      n_fail++;
      $display("FAIL sra_overlap got busy&done want never");
    end
    @(negedge clk);
    n_tests++;
    if (bus.done !== 1'b0 || bus.result !== e) begin
      n_fail++;
      $display("FAIL sra_pulse got done=%b res=%h want 0 %h",
        bus.done, bus.result, e);
    end
  endtask

  task automatic test_sll();
    int c, n; bit t, o, s; logic [31:0] e;
    issue(OP_SLL, 32'h0000_0001, 31);
    wait_done(c, t, o, s);
    pop_exp(e, n);
    n_tests++;
    if (t || bus.result !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL sll_result got %h want 80000000",
        bus.result);
    end
    n_tests++;
    if (c !== 8 || n !== 8) begin
      n_fail++;
      $display("FAIL sll_busy got %0d want 8", c);
    end
    n_tests++;
    if (!s) begin
      n_fail++;
      $display("FAIL sll_hold got changing want stable");
    end
    @(negedge clk);
  endtask

  task automatic test_srl_zero();
    int c, n; bit t, o, s; logic [31:0] e;
    issue(OP_SRL, 32'hF000_0000, 4);
    wait_done(c, t, o, s);
    pop_exp(e, n);
    n_tests++;
    if (t || bus.result !== 32'h0F00_0000 || c !== 1) begin
      n_fail++;
      $display("FAIL srl4 got %h/%0d want 0f000000/1",
        bus.result, c);
    end
    @(negedge clk);
    issue(OP_SRA, 32'hDEAD_BEEF, 0);
    wait_done(c, t, o, s);
    pop_exp(e, n);
    n_tests++;
    if (t || bus.result !== 32'hDEAD_BEEF || c !== 1) begin
      n_fail++;
      $display("FAIL sh0 got %h/%0d want deadbeef/1",
        bus.result, c);
    end
    @(negedge clk);
    issue(OP_SRA, 32'h8000_0000, 31);
    wait_done(c, t, o, s);
    pop_exp(e, n);
    n_tests++;
    if (t || bus.result !== 32'hFFFF_FFFF || c !== 8) begin
      n_fail++;
      $display("FAIL sramax got %h/%0d want ffffffff/8",
        bus.result, c);
    end
    @(negedge clk);
  endtask

  task automatic test_rotate();
    int c, n; bit t, o, s; logic [31:0] e;
    logic [31:0] want;
`ifdef SEQ_SHIFTER_ROTATE_EN
    want = 32'h7812_3456;
`else
    want = 32'h0012_3456;
`endif
    issue(OP_ROR, 32'h1234_5678, 8);
    wait_done(c, t, o, s);
    pop_exp(e, n);
    n_tests++;
    if (t || bus.result !== want || c !== 2) begin
      n_fail++;
      $display("FAIL ror got %h/%0d want %h/2",
        bus.result, c, want);
    end
    @(negedge clk);
  endtask

  task automatic test_ignore();
    int c, n; bit t, o, s; logic [31:0] e;
    bit extra;
    issue(OP_SLL, 32'h0000_0003, 30);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = OP_SRL;
    bus.a     = 32'hFFFF_FFFF;
    bus.shamt = 5'd3;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(c, t, o, s);
    pop_exp(e, n);
    n_tests++;
    if (t || bus.result !== e) begin
      n_fail++;
      $display("FAIL ignore_res got %h want %h",
        bus.result, e);
    end
    extra = 0;
    repeat (4) begin
      @(negedge clk);
      if (bus.busy || bus.done) extra = 1;
    end
    n_tests++;
    if (extra) begin
      n_fail++;
      $display("FAIL ignore_queued got activity want none");
    end
  endtask

  task automatic test_back_to_back();
    int c, n; bit t, o, s; logic [31:0] e;
    issue(OP_SRL, 32'hA5A5_0F0F, 8);
    wait_done(c, t, o, s);
    pop_exp(e, n);
    n_tests++;
    if (t || bus.result !== e) begin
      n_fail++;
      $display("FAIL b2b_first got %h want %h",
        bus.result, e);
    end
    issue(OP_SLL, 32'h0000_F00D, 13);
    n_tests++;
    if (bus.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_gap got busy=%b want 1", bus.busy);
    end
    wait_done(c, t, o, s);
    pop_exp(e, n);
    n_tests++;
    if (t || bus.result !== e || c !== n) begin
      n_fail++;
      $display("FAIL b2b_second got %h/%0d want %h/%0d",
        bus.result, c, e, n);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    bit extra;
    issue(OP_SLL, 32'h0000_0001, 31);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    exp_q.delete();
    lat_q.delete();
    n_tests++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.result !== 32'h0) begin
      n_fail++;
      $display("FAIL midrst got b=%b d=%b r=%h want 0 0 0",
        bus.busy, bus.done, bus.result);
    end
    @(negedge clk);
    rst = 1'b1;
    extra = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.busy || bus.done) extra = 1;
    end
    n_tests++;
    if (extra) begin
      n_fail++;
      $display("FAIL midrst_resume got activity want none");
    end
  endtask

  task automatic test_random();
    int c, n, sh; bit t, o, s; logic [31:0] e, a;
    op_t op;
    for (int i = 0; i < 8; i++) begin
      a  = $urandom;
      sh = $urandom_range(0, 31);
      op = op_t'($urandom_range(0, 3));
      issue(op, a, sh);
      wait_done(c, t, o, s);
      pop_exp(e, n);
      n_tests++;
      if (t || o || bus.result !== e || c !== n) begin
        n_fail++;
        $display("FAIL rnd%0d got %h/%0d want %h/%0d",
          i, bus.result, c, e, n);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    rst       = 1'b0;
    bus.start = 1'b0;
    bus.op    = OP_SLL;
    bus.a     = '0;
    bus.shamt = '0;
    #3;
    test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_sra();
    test_sll();
    test_srl_zero();
    test_rotate();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed",
      n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/seq_shifter.md
# seq_shifter

Multi-cycle, parameterised shift unit that generalises the single-cycle datapath's SRA support to SLL, SRL, SRA and optional rotate, at configurable width and per-cycle shift step. It sits beside the ALU as a start/done coprocessor. The control unit stalls the PC while `busy` is high. Its result is muxed into the register write-back path in place of the former combinational SRA result.

## Interface
- `XLEN`, 32, operand/result width; power of two, ≥8.
- `STEP`, 4, maximum bit positions shifted per cycle; power of two, 1 ≤ STEP ≤ XLEN.
- `SHW`, $clog2(XLEN), shift-amount width (derived localparam, not overridable).

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge.
- `rst`  in  1  reset; asynchronous and active-low.
- `start`  in  1  request; sampled only while `busy`=0.
- `op`  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR (see Configuration).
- `a`  in  XLEN  operand (rs1 value).
- `shamt`  in  SHW  shift amount (low SHW bits of rs2/imm).
- `busy`  out  1  high while an operation is in flight.
- `done`  out  1  one-cycle pulse; `result` valid from this cycle.
- `result`  out  XLEN  last completed result; held until the next completion.

## Operation
- FSM states:
  - IDLE: accepts a request.
  - SHIFT: steps the operation; has a remaining-count register `rem`, SHW+1 bits.
- IDLE with `start`=1 at an edge:
  - capture `a` into a working register, `op`, and `rem`=`shamt`;
  - latch the SRA fill bit as a[XLEN-1];
  - `busy`←1, go to SHIFT.
- SHIFT, each edge:
  - k = min(STEP, rem);
  - shift the working register by k per `op` (SLL zero-fill; SRL zero-fill; SRA fill with latched sign; ROR wrap);
  - `rem` ← `rem` − k.
- SHIFT completion: the edge where `rem` becomes 0, or the first SHIFT edge when `rem` was already 0.
  - `result` ← shifted value;
  - `done`←1 for one cycle, `busy`←0, go to IDLE.
- `start` while `busy`=1 is ignored; no queueing.
- `done` and `busy` are never high in the same cycle.
- `start` in the same cycle as `done` is accepted; back-to-back operations carry no bubble.
- shamt=0: result = a.
- Maximum shamt (XLEN−1) is handled exactly; no modulo error.
- Async reset (`rst`=0), including mid-operation:
  - state→IDLE;
  - `busy`=0, `done`=0, `result`=0, `rem`=0, working register=0;
  - the in-flight operation is discarded.

## Timing
- Latency N = max(1, ceil(shamt/STEP)) cycles, counted from the capture edge to the edge that raises `done`.
- `busy` is high for exactly N cycles.
- Throughput: one operation per N cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `result` stays stable while `busy`=1, because the working register is internal.

## Configuration
- `SEQ_SHIFTER_ROTATE_EN` defined:
  - op=11 performs rotate-right; bits shifted out of bit 0 re-enter at bit XLEN−1.
- Not defined:
  - rotate logic is absent;
  - op=11 executes as SRL (zero-fill), with identical latency.

## Structure
- Package `seq_shifter_pkg`:
  - op encodings `OP_SLL`, `OP_SRL`, `OP_SRA`, `OP_ROR`;
  - FSM state typedef `shstate_t` {IDLE, SHIFT}.
- Sub-module `shift_step`: combinational single-step shifter. Inputs: value, k (0..STEP), op, fill bit. One instance, driven by the FSM.

## Test plan
- SRA, XLEN=32, STEP=4: a=0x80000010, shamt=5, start 1 cycle → busy 2 cycles; done pulse; result=0xFC000000.
- SLL: a=0x00000001, shamt=31 → N=8 busy cycles; result=0x80000000; result holds previous value throughout.
- SRL and zero: a=0xF0000000, shamt=4 → N=1, result=0x0F000000. Then a=0xDEADBEEF, shamt=0 → N=1, result=0xDEADBEEF.
- Rotate: a=0x12345678, shamt=8, op=11 → result=0x78123456 with `SEQ_SHIFTER_ROTATE_EN`; 0x00123456 without.
- Handshake:
  - start pulsed mid-busy with different operands → ignored; original result returned.
  - start asserted in the done cycle → second operation completes after its own N cycles, with no idle cycle between.
- Reset: `rst` low during the 4th of 8 busy cycles → busy, done, result all 0 immediately (asynchronously). After release, no done pulse until a new start.
